// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: state encoding and default parameters
// shared by the Wishbone-to-SDRAM bridge.
package sdram_bridge_pkg;

   localparam int          ADDR_W           = 23;
   localparam logic [31:0] DEF_BASE_ADDR    = 32'h3800_0000;
   localparam logic [31:0] DEF_ADDR_MASK    = 32'hFF80_0000;
   localparam int          DEF_TIMEOUT      = 1023;
   localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_ACCEPT,
      S_CHECK,
      S_WAIT_RD,
      S_WAIT_WR,
      S_MERGE,
      S_ACK
   } state_t;

endpackage

// File: rtl/sdram_byte_merge.sv
// sdram_byte_merge: per-lane select of new write bytes over
// old read bytes for the bridge's read-modify-write path.
module sdram_byte_merge (
   input  logic [3:0]  sel,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] merged
);

   always_comb begin
      merged = rdata;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
   end

endmodule

// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge: Wishbone classic slave to SDRAM controller.
// Define SDRAM_BRIDGE_RMW_EN for byte-lane writes via read-modify-write.
module sdram_wb_bridge
   import sdram_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
   parameter logic [31:0] ADDR_MASK    = DEF_ADDR_MASK,
   parameter int          TIMEOUT      = DEF_TIMEOUT,
   parameter logic [31:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic              ctrl_rw,
   output logic [31:0]       ctrl_wdata,
   output logic              ctrl_in_valid,
   input  logic              ctrl_busy,
   input  logic [31:0]       ctrl_rdata,
   input  logic              ctrl_out_valid,
   output logic              timeout_o
);

   localparam int            CW  = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t        state;
   state_t        rd_next;
   logic [CW-1:0] cnt;
   logic          we;
   logic          wr_ph;
   logic          abort;
   logic [31:0]   rdata;
   logic          hit;
   logic          counting;
   logic          tmo;

   assign hit = wbs_cyc_i & wbs_stb_i &
                ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
   assign counting = (state == S_ISSUE) | (state == S_CHECK) |
                     (state == S_WAIT_RD) | (state == S_WAIT_WR);
   assign tmo = (cnt == TMO);

`ifdef SDRAM_BRIDGE_RMW_EN
   logic        rmw;
   logic [3:0]  sel;
   logic [31:0] merged;

   // ctrl_wdata still holds the master's data until MERGE.
   sdram_byte_merge u_merge (
      .sel    (sel),
      .wdata  (ctrl_wdata),
      .rdata  (rdata),
      .merged (merged)
   );

   assign rd_next = rmw ? S_MERGE : S_ACK;
`else
   assign rd_next = S_ACK;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         we            <= 1'b0;
         wr_ph         <= 1'b0;
         abort         <= 1'b0;
         rdata         <= '0;
         wbs_ack_o     <= 1'b0;
         wbs_dat_o     <= '0;
         ctrl_addr     <= '0;
         ctrl_rw       <= 1'b0;
         ctrl_wdata    <= '0;
         ctrl_in_valid <= 1'b0;
         timeout_o     <= 1'b0;
`ifdef SDRAM_BRIDGE_RMW_EN
         rmw           <= 1'b0;
         sel           <= '0;
`endif
      end else begin
         wbs_ack_o     <= 1'b0;
         ctrl_in_valid <= 1'b0;
         timeout_o     <= 1'b0;
         if (state != S_IDLE && !wbs_cyc_i) abort <= 1'b1;
         if (counting && tmo) begin
            timeout_o <= 1'b1;
            if (!wr_ph) rdata <= TIMEOUT_DATA;
            state <= S_ACK;
         end else begin
            if (counting) cnt <= cnt + CW'(1);
            unique case (state)
               S_IDLE: begin
                  // ack_o high means this stb was just acknowledged
                  if (hit && !wbs_ack_o) begin
                     ctrl_addr  <= {wbs_adr_i[22:2], 2'b00};
                     ctrl_wdata <= wbs_dat_i;
                     we         <= wbs_we_i;
                     abort      <= 1'b0;
                     cnt        <= '0;
`ifdef SDRAM_BRIDGE_RMW_EN
                     sel   <= wbs_sel_i;
                     rmw   <= wbs_we_i & (wbs_sel_i != 4'hF);
                     wr_ph <= wbs_we_i & (wbs_sel_i == 4'hF);
`else
                     wr_ph <= wbs_we_i;
`endif
                     if (wbs_we_i && wbs_sel_i == 4'h0)
                        state <= S_ACK;
                     else
                        state <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (!ctrl_busy) begin
                     ctrl_in_valid <= 1'b1;
                     ctrl_rw       <= wr_ph;
                     state         <= S_ACCEPT;
                  end
               end
               S_ACCEPT: state <= S_CHECK;
               S_CHECK: begin
                  if (!wr_ph && ctrl_out_valid) begin
                     rdata <= ctrl_rdata;
                     state <= rd_next;
                  end else if (ctrl_busy) begin
                     state <= wr_ph ? S_WAIT_WR : S_WAIT_RD;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
               S_WAIT_RD: begin
                  if (ctrl_out_valid) begin
                     rdata <= ctrl_rdata;
                     state <= rd_next;
                  end
               end
               S_WAIT_WR: if (!ctrl_busy) state <= S_ACK;
`ifdef SDRAM_BRIDGE_RMW_EN
               S_MERGE: begin
                  ctrl_wdata <= merged;
                  wr_ph      <= 1'b1;
                  cnt        <= '0;
                  state      <= S_ISSUE;
               end
`endif
               S_ACK: begin
                  if (!abort && wbs_cyc_i) begin
                     wbs_ack_o <= 1'b1;
                     if (!we) wbs_dat_o <= rdata;
                  end
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb_sdram_wb_bridge: drives Wishbone cycles against a behavioural
// SDRAM controller and checks results against a word-level memory model.
module tb_sdram_wb_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [22:0] ctrl_addr;
   logic        ctrl_rw;
   logic [31:0] ctrl_wdata;
   logic        ctrl_in_valid;
   logic        ctrl_busy;
   logic [31:0] ctrl_rdata;
   logic        ctrl_out_valid;
   logic        timeout_o;

   int checks = 0;
   int errors = 0;

   sdram_wb_bridge dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wbs_cyc_i      (wbs_cyc_i),
      .wbs_stb_i      (wbs_stb_i),
      .wbs_we_i       (wbs_we_i),
      .wbs_sel_i      (wbs_sel_i),
      .wbs_adr_i      (wbs_adr_i),
      .wbs_dat_i      (wbs_dat_i),
      .wbs_ack_o      (wbs_ack_o),
      .wbs_dat_o      (wbs_dat_o),
      .ctrl_addr      (ctrl_addr),
      .ctrl_rw        (ctrl_rw),
      .ctrl_wdata     (ctrl_wdata),
      .ctrl_in_valid  (ctrl_in_valid),
      .ctrl_busy      (ctrl_busy),
      .ctrl_rdata     (ctrl_rdata),
      .ctrl_out_valid (ctrl_out_valid),
      .timeout_o      (timeout_o)
   );

   always #5 clk = ~clk;

   // behavioural controller
   typedef struct packed {
      logic        rw;
      logic [22:0] addr;
      logic [31:0] wdata;
   } op_t;

   op_t         ops[$];
   logic [31:0] mem[int];
   int          lat = 0;
   bit          hitm = 1'b0;
   bit          dead = 1'b0;
   int          drop_until = 0;
   int          iv_cnt = 0;
   int          viol = 0;
   int          tmo_cnt = 0;
   int          cyc_n = 0;
   int          fall_edge = 0;
   int          ack_edge = 0;
   logic        pend, prw, busy_d, iv_d;
   logic [22:0] paddr;
   logic [31:0] pwd;
   int          lcnt;

   function automatic logic [31:0] mrd(logic [22:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_busy      <= 1'b0;
         ctrl_out_valid <= 1'b0;
         ctrl_rdata     <= '0;
         pend           <= 1'b0;
         prw            <= 1'b0;
         busy_d         <= 1'b0;
         iv_d           <= 1'b0;
         lcnt           <= 0;
      end else begin
         ctrl_out_valid <= 1'b0;
         if (ctrl_in_valid) begin
            if (busy_d || iv_d) viol++;
            iv_cnt++;
            if (iv_cnt <= drop_until) begin
            end else if (dead) begin
               ctrl_busy <= 1'b1;
            end else begin
               ops.push_back({ctrl_rw, ctrl_addr, ctrl_wdata});
               if (!ctrl_rw && hitm) begin
                  ctrl_out_valid <= 1'b1;
                  ctrl_rdata     <= mrd(ctrl_addr);
               end else begin
                  ctrl_busy <= 1'b1;
                  pend      <= 1'b1;
                  prw       <= ctrl_rw;
                  paddr     <= ctrl_addr;
                  pwd       <= ctrl_wdata;
                  lcnt      <= lat;
               end
            end
         end else if (pend) begin
            if (lcnt == 0) begin
               ctrl_busy <= 1'b0;
               pend      <= 1'b0;
               fall_edge = cyc_n;
               if (prw) begin
                  mem[int'(paddr)] = pwd;
               end else begin
                  ctrl_out_valid <= 1'b1;
                  ctrl_rdata     <= mrd(paddr);
               end
            end else begin
               lcnt <= lcnt - 1;
            end
         end
         busy_d <= ctrl_busy;
         iv_d   <= ctrl_in_valid;
      end
   end

   always @(negedge clk) begin
      cyc_n++;
      if (timeout_o) tmo_cnt++;
   end

   // expected word after a write, from the byte-enable rules
   function automatic logic [31:0] exp_wr(logic [31:0] old,
                                          logic [31:0] d,
                                          logic [3:0] s);
      logic [31:0] r;
      if (s == 4'h0) return old;
`ifdef SDRAM_BRIDGE_RMW_EN
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
`else
      r = d;
`endif
      return r;
   endfunction

   task automatic wb_req(input logic [31:0] adr,
                         input logic        we,
                         input logic [3:0]  sel,
                         input logic [31:0] dat,
                         input int          budget,
                         output logic [31:0] rd,
                         output int         n,
                         output bit         acked,
                         output bit         extra);
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_sel_i = sel;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      n = 0;
      acked = 1'b0;
      extra = 1'b0;
      while (!acked && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (wbs_ack_o) acked = 1'b1;
      end
      rd = wbs_dat_o;
      ack_edge = cyc_n;
      if (acked) begin
         @(posedge clk); #1;
         extra = wbs_ack_o;
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (wbs_ack_o) extra = 1'b1;
      end
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wbs_ack_o, wbs_dat_o, ctrl_addr, ctrl_rw, ctrl_wdata,
           ctrl_in_valid, timeout_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs ack=%b dat=%h addr=%h iv=%b",
                  wbs_ack_o, wbs_dat_o, ctrl_addr, ctrl_in_valid);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_write_read;
      logic [31:0] rd;
      int n, iv0;
      bit ok, xa;
      ops.delete();
      lat = 3;
      hitm = 1'b0;
      iv0 = iv_cnt;
      wb_req(32'h3800_0010, 1'b1, 4'hF, 32'h1234_5678, 100,
             rd, n, ok, xa);
      checks++;
      if (!ok || xa) begin
         errors++;
         $display("FAIL wr_ack acked=%0b extra=%0b want 1/0", ok, xa);
      end
      checks++;
      if (iv_cnt - iv0 != 1 || ops.size() != 1) begin
         errors++;
         $display("FAIL wr_pulses iv=%0d ops=%0d want 1/1",
                  iv_cnt - iv0, ops.size());
      end else begin
         checks++;
         if (ops[0] !== {1'b1, 23'h10, 32'h1234_5678}) begin
            errors++;
            $display("FAIL wr_op got %h want %h", ops[0],
                     {1'b1, 23'h10, 32'h1234_5678});
         end
      end
      checks++;
      if (ack_edge - fall_edge < 1 || ack_edge - fall_edge > 2) begin
         errors++;
         $display("FAIL wr_ack_after_busy delta=%0d want 1..2",
                  ack_edge - fall_edge);
      end
      ops.delete();
      hitm = 1'b1;
      wb_req(32'h3800_0010, 1'b0, 4'hF, 32'h0, 100, rd, n, ok, xa);
      checks++;
      if (rd !== 32'h1234_5678 || !ok || xa) begin
         errors++;
         $display("FAIL rd_data got %h want 12345678 ack=%0b x=%0b",
                  rd, ok, xa);
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL rd_hit_latency got %0d want 5", n);
      end
      checks++;
      if (ops.size() != 1 || ops[0].rw !== 1'b0 ||
          ops[0].addr !== 23'h10) begin
         errors++;
         $display("FAIL rd_op size=%0d want one read of 0x10",
                  ops.size());
      end
   endtask

   task automatic test_sel0;
      logic [31:0] rd;
      int n, iv0;
      bit ok, xa;
      iv0 = iv_cnt;
      wb_req(32'h3800_0010, 1'b1, 4'h0, 32'hFFFF_FFFF, 50,
             rd, n, ok, xa);
      checks++;
      if (!ok || n != 2 || iv_cnt != iv0) begin
         errors++;
         $display("FAIL sel0 ack=%0b lat=%0d iv=%0d want 1/2/0",
                  ok, n, iv_cnt - iv0);
      end
   endtask

   task automatic test_rmw;
      logic [31:0] rd, want;
      int n;
      bit ok, xa;
      lat = 2;
      hitm = 1'b0;
      wb_req(32'h3800_0020, 1'b1, 4'hF, 32'hAABB_CCDD, 100,
             rd, n, ok, xa);
      ops.delete();
      wb_req(32'h3800_0020, 1'b1, 4'b0101, 32'h1122_3344, 100,
             rd, n, ok, xa);
      want = exp_wr(32'hAABB_CCDD, 32'h1122_3344, 4'b0101);
      checks++;
      if (!ok || mrd(23'h20) !== want) begin
         errors++;
         $display("FAIL rmw_mem got %h want %h ack=%0b",
                  mrd(23'h20), want, ok);
      end
`ifdef SDRAM_BRIDGE_RMW_EN
      checks++;
      if (ops.size() != 2 || ops[0].rw !== 1'b0 ||
          ops[1] !== {1'b1, 23'h20, 32'hAA22_CC44}) begin
         errors++;
         $display("FAIL rmw_ops size=%0d want read then write AA22CC44",
                  ops.size());
      end
`else
      checks++;
      if (ops.size() != 1 || ops[0] !== {1'b1, 23'h20, 32'h1122_3344}) begin
         errors++;
         $display("FAIL fullword_ops size=%0d want one write 11223344",
                  ops.size());
      end
`endif
   endtask

   task automatic test_drop;
      logic [31:0] rd, d;
      int n, iv0;
      bit ok, xa;
      d = $urandom;
      ops.delete();
      lat = 1;
      iv0 = iv_cnt;
      drop_until = iv_cnt + 1;
      wb_req(32'h3800_0030, 1'b1, 4'hF, d, 100, rd, n, ok, xa);
      checks++;
      if (!ok || xa || iv_cnt - iv0 != 2 || ops.size() != 1 ||
          mrd(23'h30) !== d) begin
         errors++;
         $display("FAIL drop_wr ack=%0b x=%0b iv=%0d ops=%0d mem=%h want %h",
                  ok, xa, iv_cnt - iv0, ops.size(), mrd(23'h30), d);
      end
      hitm = 1'b1;
      iv0 = iv_cnt;
      drop_until = iv_cnt + 2;
      wb_req(32'h3800_0030, 1'b0, 4'hF, 32'h0, 100, rd, n, ok, xa);
      checks++;
      if (!ok || xa || iv_cnt - iv0 != 3 || rd !== d) begin
         errors++;
         $display("FAIL drop_rd ack=%0b x=%0b iv=%0d rd=%h want %h",
                  ok, xa, iv_cnt - iv0, rd, d);
      end
   endtask

   task automatic test_miss;
      logic [31:0] rd;
      int n, iv0;
      bit ok, xa;
      iv0 = iv_cnt;
      wb_req(32'h3900_0000, 1'b1, 4'hF, 32'h5555_AAAA, 20,
             rd, n, ok, xa);
      checks++;
      if (ok || iv_cnt != iv0) begin
         errors++;
         $display("FAIL miss ack=%0b iv=%0d want 0/0", ok, iv_cnt - iv0);
      end
   endtask

   task automatic test_random;
      logic [31:0] ref_m[8];
      logic [31:0] rd;
      int n;
      bit ok, xa;
      for (int i = 0; i < 8; i++) begin
         ref_m[i] = $urandom;
         lat = 0;
         wb_req(32'h3800_0100 + 32'(i * 4), 1'b1, 4'hF, ref_m[i], 50,
                rd, n, ok, xa);
      end
      for (int k = 0; k < 40; k++) begin
         int w;
         logic we;
         logic [3:0] s;
         logic [31:0] d, a;
         w = $urandom_range(0, 7);
         we = 1'($urandom_range(0, 1));
         s = 4'($urandom);
         d = $urandom;
         a = 32'h3800_0100 + 32'(w * 4) + 32'($urandom_range(0, 3));
         lat = $urandom_range(0, 4);
         hitm = 1'($urandom_range(0, 1));
         drop_until = iv_cnt + $urandom_range(0, 1);
         wb_req(a, we, s, d, 200, rd, n, ok, xa);
         checks++;
         if (!ok || xa || (!we && rd !== ref_m[w])) begin
            errors++;
            $display("FAIL rand_op%0d we=%0b ack=%0b x=%0b rd=%h want %h",
                     k, we, ok, xa, rd, ref_m[w]);
         end
         if (we) ref_m[w] = exp_wr(ref_m[w], d, s);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (mrd(23'(32'h100 + 32'(i * 4))) !== ref_m[i]) begin
            errors++;
            $display("FAIL rand_mem%0d got %h want %h", i,
                     mrd(23'(32'h100 + 32'(i * 4))), ref_m[i]);
         end
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL in_valid_rules violations=%0d want 0", viol);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd;
      int n;
      bit ok, xa;
      lat = 30;
      hitm = 1'b0;
      drop_until = 0;
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 32'h3800_0040;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      #1;
      checks++;
      if ({wbs_ack_o, wbs_dat_o, ctrl_addr, ctrl_rw, ctrl_wdata,
           ctrl_in_valid, timeout_o} !== '0) begin
         errors++;
         $display("FAIL midop_reset ack=%b dat=%h addr=%h wd=%h",
                  wbs_ack_o, wbs_dat_o, ctrl_addr, ctrl_wdata);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      lat = 1;
      wb_req(32'h3800_0010, 1'b0, 4'hF, 32'h0, 100, rd, n, ok, xa);
      checks++;
      if (!ok || rd !== 32'h1234_5678) begin
         errors++;
         $display("FAIL after_reset ack=%0b rd=%h want 12345678", ok, rd);
      end
   endtask

   task automatic test_timeout;
      logic [31:0] rd;
      int n, t0;
      bit ok, xa;
      dead = 1'b1;
      drop_until = 0;
      t0 = tmo_cnt;
      wb_req(32'h3800_0044, 1'b0, 4'hF, 32'h0, 2000, rd, n, ok, xa);
      checks++;
      if (!ok || rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL timeout_data ack=%0b rd=%h want deadbeef", ok, rd);
      end
      checks++;
      if (tmo_cnt - t0 != 1 || n < 1023 || n > 1030) begin
         errors++;
         $display("FAIL timeout_pulse pulses=%0d lat=%0d want 1/1023..1030",
                  tmo_cnt - t0, n);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_sel0();
      test_rmw();
      test_drop();
      test_miss();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_wb_bridge.md
# sdram_wb_bridge

Wishbone B4 classic slave that turns user-project bus cycles into single-word requests for the SDRAM controller. It sits directly upstream of the controller, on the `user_addr` / `rw` / `in_valid` / `busy` / `out_valid` port. It decodes an 8 MB window and handles the controller's pulse/busy handshake, including retry on a dropped request. It also implements byte-lane writes by read-modify-write, because the controller has no byte mask.

## Interface
Parameters:
- BASE_ADDR, 32'h3800_0000, window base
- ADDR_MASK, 32'hFF80_0000, bits compared against BASE_ADDR (8 MB window)
- TIMEOUT, 1023, max cycles waiting on the controller per request phase
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone cycle, strobe, write enable
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data
- ctrl_addr  out  23  to controller `user_addr`
- ctrl_rw  out  1  1 = write
- ctrl_wdata  out  32  to controller `data_in`
- ctrl_in_valid  out  1  request pulse
- ctrl_busy  in  1  controller busy
- ctrl_rdata  in  32  controller `data_out`
- ctrl_out_valid  in  1  read data valid
- timeout_o  out  1  one-cycle pulse when a request times out

## Operation
- Hit condition: `cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR)`. A miss is ignored; no ack is issued.
- On a hit in IDLE, latch the request:
  - `ctrl_addr = {adr[22:2], 2'b00}`
  - `we`, `sel`, `dat_i`
- States: IDLE, ISSUE, ACCEPT, CHECK, WAIT_RD, WAIT_WR, MERGE, ACK.
- ISSUE: when `ctrl_busy == 0`, register `ctrl_in_valid = 1` together with `ctrl_rw`, `ctrl_addr` and `ctrl_wdata`, then go to ACCEPT.
- ACCEPT: `ctrl_in_valid` returns to 0; go to CHECK.
- CHECK:
  - Read phase with `ctrl_out_valid = 1` (controller cache hit): capture `ctrl_rdata`; go to MERGE if RMW, else ACK.
  - `ctrl_busy = 1`: go to WAIT_RD (read phase) or WAIT_WR (write phase).
  - Neither: the request was dropped; go back to ISSUE (unbounded retry, bounded by the timeout).
- WAIT_RD: on `ctrl_out_valid`, capture `ctrl_rdata`; go to MERGE (RMW) or ACK.
- WAIT_WR: on `ctrl_busy == 0`, go to ACK.
- MERGE: for each byte lane b, `merged[b] = sel[b] ? dat_i[b] : rdata[b]`. Load `ctrl_wdata = merged`, set phase = write, go to ISSUE.
- ACK: `wbs_ack_o = 1` for exactly one cycle, with `wbs_dat_o` = captured read data (writes: unchanged). Go to IDLE.
  - IDLE ignores `stb` during the cycle in which ACK is registered, so a request cannot be taken twice.
- Timeout:
  - A counter clears on entry to ISSUE and increments in ISSUE, CHECK, WAIT_RD and WAIT_WR.
  - When it reaches TIMEOUT: pulse `timeout_o` and go to ACK.
  - Read phase: `wbs_dat_o = TIMEOUT_DATA`. Write phase: ack with no write guarantee.
- Master abort: if `cyc` drops mid-request, the controller operation still completes (including the RMW write) and ACK is suppressed; go to IDLE.
- Reset, asynchronous, also valid mid-operation: state = IDLE, counter = 0. All outputs are 0:
  - `wbs_ack_o`, `wbs_dat_o`
  - `ctrl_addr`, `ctrl_rw`, `ctrl_wdata`, `ctrl_in_valid`
  - `timeout_o`

## Timing
- All outputs are registered.
- `ctrl_in_valid` is high exactly 1 cycle per issue and is never asserted while `ctrl_busy` was high in the issuing cycle.
- Read latency, stb to ack, with an idle controller and a cache hit: 5 cycles (IDLE, ISSUE, ACCEPT, CHECK, ACK).
- Plain write: ack 1 cycle after busy falls.
- RMW: read phase + 1 (MERGE) + write phase.
- `sel == 4'h0` write: no controller access; ack 2 cycles after stb.

## Configuration
- `SDRAM_BRIDGE_RMW_EN` defined:
  - a write with `sel != 4'hF` and `sel != 4'h0` runs read, MERGE, write;
  - `sel == 4'hF` is a plain write.
- Not defined:
  - MERGE state and merge logic are absent;
  - every write is a full-word write of `wbs_dat_i`;
  - `sel` is ignored except for the `4'h0` no-op rule.

## Structure
- Package `sdram_bridge_pkg`:
  - state enum;
  - default BASE_ADDR, ADDR_MASK, TIMEOUT and TIMEOUT_DATA constants;
  - address-width constant (23).
- Sub-module `sdram_byte_merge`: combinational 4-lane merge (sel, new, old → merged), instantiated only under `SDRAM_BRIDGE_RMW_EN`.

## Test plan
- Write `0x3800_0010` = `0x1234_5678`, `sel = F` → one `in_valid` pulse with `ctrl_addr = 0x10`, `ctrl_rw = 1`, `ctrl_wdata = 0x1234_5678`; ack after busy falls.
- Read the same address; controller model returns `0x1234_5678` via `out_valid` → `wbs_dat_o = 0x1234_5678`, single ack.
- RMW enabled: word holds `0xAABB_CCDD`; write `0x1122_3344` with `sel = 4'b0101` → controller sees a read, then a write of `0xAA22_CC44`.
- Controller model ignores the first `in_valid` (busy stays 0) → bridge re-issues; exactly one operation completes; one ack.
- Controller never responds to a read → `timeout_o` pulses after 1023 cycles; ack with `0xDEAD_BEEF`.
- Address `0x3900_0000` → no `ctrl_in_valid` and no ack. `rst_n` asserted during WAIT_RD → all outputs 0 immediately; next request proceeds normally.
